// File: rtl/stopwatch_timer.sv
// MM:SS BCD stopwatch/countdown with up/down counting, per-field adjust, toggle pause
// and one-cycle terminal-count (done) / rollover (wrap) strobes.
module stopwatch_timer #(
  parameter int MIN_TOP = 59,
  parameter int SEC_TOP = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       adj_tick,
  input  logic       adj,
  input  logic       sel,
  input  logic       pse,
  input  logic       dir,
  output logic [3:0] sec_one,
  output logic [3:0] sec_ten,
  output logic [3:0] min_one,
  output logic [3:0] min_ten,
  output logic       paused,
  output logic       done,
  output logic       wrap
);

  localparam logic [3:0] SEC_TOP_TEN = 4'(SEC_TOP / 10);
  localparam logic [3:0] SEC_TOP_ONE = 4'(SEC_TOP % 10);
  localparam logic [3:0] MIN_TOP_TEN = 4'(MIN_TOP / 10);
  localparam logic [3:0] MIN_TOP_ONE = 4'(MIN_TOP % 10);

  // Result packing: {carry/borrow, ten, one}
  function automatic logic [8:0] bcd_inc(input logic [3:0] ten, input logic [3:0] one,
                                         input logic [3:0] top_ten, input logic [3:0] top_one);
    if ((ten > top_ten) || ((ten == top_ten) && (one >= top_one)))
      return 9'h100;
    else if (one == 4'd9)
      return {1'b0, ten + 4'd1, 4'd0};
    else
      return {1'b0, ten, one + 4'd1};
  endfunction

  function automatic logic [8:0] bcd_dec(input logic [3:0] ten, input logic [3:0] one,
                                         input logic [3:0] top_ten, input logic [3:0] top_one);
    if ((ten == 4'd0) && (one == 4'd0))
      return {1'b1, top_ten, top_one};
    else if (one == 4'd0)
      return {1'b0, ten - 4'd1, 4'd9};
    else
      return {1'b0, ten, one - 4'd1};
  endfunction

  logic       pse_q;
  logic [8:0] sec_inc, sec_dec, min_inc, min_dec;
  logic [3:0] nxt_sec_one, nxt_sec_ten, nxt_min_one, nxt_min_ten;
  logic       nxt_paused, nxt_done, nxt_wrap;
  logic       at_zero;

  assign sec_inc = bcd_inc(sec_ten, sec_one, SEC_TOP_TEN, SEC_TOP_ONE);
  assign sec_dec = bcd_dec(sec_ten, sec_one, SEC_TOP_TEN, SEC_TOP_ONE);
  assign min_inc = bcd_inc(min_ten, min_one, MIN_TOP_TEN, MIN_TOP_ONE);
  assign min_dec = bcd_dec(min_ten, min_one, MIN_TOP_TEN, MIN_TOP_ONE);
  assign at_zero = ({min_ten, min_one, sec_ten, sec_one} == 16'h0000);

  always_comb begin
    nxt_sec_one = sec_one;
    nxt_sec_ten = sec_ten;
    nxt_min_one = min_one;
    nxt_min_ten = min_ten;
    nxt_done    = 1'b0;
    nxt_wrap    = 1'b0;
    // Count uses the registered paused value, so an edge in the same cycle doesn't affect it
    nxt_paused  = paused ^ (pse & ~pse_q);

    if (adj) begin
      if (adj_tick) begin
        if (sel) {nxt_sec_ten, nxt_sec_one} = sec_inc[7:0];
        else     {nxt_min_ten, nxt_min_one} = min_inc[7:0];
      end
    end else if (tick && !paused) begin
      if (!dir) begin
        {nxt_sec_ten, nxt_sec_one} = sec_inc[7:0];
        if (sec_inc[8]) begin
          {nxt_min_ten, nxt_min_one} = min_inc[7:0];
          nxt_wrap = min_inc[8];
        end
      end else if (!at_zero) begin
        {nxt_sec_ten, nxt_sec_one} = sec_dec[7:0];
        if (sec_dec[8]) {nxt_min_ten, nxt_min_one} = min_dec[7:0];
        nxt_done = ({nxt_min_ten, nxt_min_one, nxt_sec_ten, nxt_sec_one} == 16'h0000);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_one <= 4'd0;
      sec_ten <= 4'd0;
      min_one <= 4'd0;
      min_ten <= 4'd0;
      paused  <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      pse_q   <= 1'b0;
    end else begin
      sec_one <= nxt_sec_one;
      sec_ten <= nxt_sec_ten;
      min_one <= nxt_min_one;
      min_ten <= nxt_min_ten;
      paused  <= nxt_paused;
      done    <= nxt_done;
      wrap    <= nxt_wrap;
      pse_q   <= pse;
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed self-checking bench for stopwatch_timer (default 59:59 ceilings).
module tb_stopwatch_timer;

  logic       clk = 1'b0;
  logic       rst, tick, adj_tick, adj, sel, pse, dir;
  logic [3:0] sec_one, sec_ten, min_one, min_ten;
  logic       paused, done, wrap;
  int         tests = 0;
  int         fails = 0;

  stopwatch_timer #(.MIN_TOP(59), .SEC_TOP(59)) dut (
    .clk(clk), .rst(rst), .tick(tick), .adj_tick(adj_tick), .adj(adj), .sel(sel),
    .pse(pse), .dir(dir), .sec_one(sec_one), .sec_ten(sec_ten), .min_one(min_one),
    .min_ten(min_ten), .paused(paused), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {min_ten, min_one, sec_ten, sec_one};
  endfunction

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic do_adj_tick();
    @(negedge clk); adj_tick = 1'b1;
    @(negedge clk); adj_tick = 1'b0;
  endtask

  task automatic pse_edge();
    @(negedge clk); pse = 1'b1;
    @(negedge clk); pse = 1'b0;
  endtask

  // Reset then load MM:SS through adjust mode
  task automatic set_time(input int m, input int s);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    adj = 1'b1; sel = 1'b1;
    for (int i = 0; i < s; i++) do_adj_tick();
    sel = 1'b0;
    for (int i = 0; i < m; i++) do_adj_tick();
    adj = 1'b0;
  endtask

  task automatic test_reset();
    set_time(12, 34);
    tests++;
    if (digits() !== 16'h1234) begin
      fails++; $display("FAIL reset_preload: got %h want 1234", digits());
    end
    pse_edge();
    @(negedge clk); tick = 1'b1; dir = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (digits() !== 16'h0000 || paused !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      fails++; $display("FAIL reset_async: got %h p=%b d=%b w=%b want 0000 p=0 d=0 w=0",
                        digits(), paused, done, wrap);
    end
    @(negedge clk); rst = 1'b0; tick = 1'b0;
    @(negedge clk);
    tests++;
    if (digits() !== 16'h0000 || paused !== 1'b0) begin
      fails++; $display("FAIL reset_release: got %h p=%b want 0000 p=0", digits(), paused);
    end
  endtask

  task automatic test_count_up();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'h0059; exp_v[1] = 16'h0100; exp_v[2] = 16'h0101;
    set_time(0, 58);
    dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      tests++;
      if (digits() !== exp_v[i] || wrap !== 1'b0) begin
        fails++; $display("FAIL count_up_%0d: got %h w=%b want %h w=0", i, digits(), wrap, exp_v[i]);
      end
    end
  endtask

  task automatic test_wrap();
    set_time(59, 59);
    dir = 1'b0;
    do_tick();
    tests++;
    if (digits() !== 16'h0000 || wrap !== 1'b1) begin
      fails++; $display("FAIL wrap_rollover: got %h w=%b want 0000 w=1", digits(), wrap);
    end
    @(negedge clk);
    tests++;
    if (wrap !== 1'b0 || digits() !== 16'h0000) begin
      fails++; $display("FAIL wrap_one_cycle: got %h w=%b want 0000 w=0", digits(), wrap);
    end
  endtask

  task automatic test_count_down();
    set_time(1, 0);
    dir = 1'b1;
    do_tick();
    tests++;
    if (digits() !== 16'h0059 || done !== 1'b0) begin
      fails++; $display("FAIL down_borrow: got %h d=%b want 0059 d=0", digits(), done);
    end
    set_time(0, 1);
    do_tick();
    tests++;
    if (digits() !== 16'h0000 || done !== 1'b1) begin
      fails++; $display("FAIL down_done: got %h d=%b want 0000 d=1", digits(), done);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL done_one_cycle: got d=%b want d=0", done);
    end
    do_tick(); do_tick();
    tests++;
    if (digits() !== 16'h0000 || done !== 1'b0) begin
      fails++; $display("FAIL down_hold_zero: got %h d=%b want 0000 d=0", digits(), done);
    end
    dir = 1'b0;
  endtask

  task automatic test_pause();
    set_time(0, 10);
    dir = 1'b0;
    pse_edge();
    tests++;
    if (paused !== 1'b1) begin
      fails++; $display("FAIL pause_on: got p=%b want p=1", paused);
    end
    for (int i = 0; i < 5; i++) do_tick();
    tests++;
    if (digits() !== 16'h0010) begin
      fails++; $display("FAIL pause_hold: got %h want 0010", digits());
    end
    pse_edge();
    do_tick();
    tests++;
    if (digits() !== 16'h0011 || paused !== 1'b0) begin
      fails++; $display("FAIL pause_resume: got %h p=%b want 0011 p=0", digits(), paused);
    end
    @(negedge clk); pse = 1'b1; tick = 1'b1;
    @(negedge clk); pse = 1'b0; tick = 1'b0;
    tests++;
    if (digits() !== 16'h0012 || paused !== 1'b1) begin
      fails++; $display("FAIL pause_edge_with_tick: got %h p=%b want 0012 p=1", digits(), paused);
    end
    pse_edge();
  endtask

  task automatic test_adjust();
    set_time(0, 59);
    adj = 1'b1; sel = 1'b1;
    do_adj_tick();
    tests++;
    if (digits() !== 16'h0000) begin
      fails++; $display("FAIL adj_sec_wrap: got %h want 0000", digits());
    end
    set_time(59, 10);
    adj = 1'b1; sel = 1'b0;
    do_adj_tick();
    tests++;
    if (digits() !== 16'h0010 || wrap !== 1'b0) begin
      fails++; $display("FAIL adj_min_wrap: got %h w=%b want 0010 w=0", digits(), wrap);
    end
    for (int i = 0; i < 3; i++) do_tick();
    tests++;
    if (digits() !== 16'h0010) begin
      fails++; $display("FAIL adj_ignores_tick: got %h want 0010", digits());
    end
    adj = 1'b0;
    @(negedge clk); tick = 1'b1; adj_tick = 1'b1;
    @(negedge clk); tick = 1'b0; adj_tick = 1'b0;
    tests++;
    if (digits() !== 16'h0011) begin
      fails++; $display("FAIL coincident_enables: got %h want 0011", digits());
    end
    dir = 1'b1; adj = 1'b1; sel = 1'b1;
    do_adj_tick();
    tests++;
    if (digits() !== 16'h0012) begin
      fails++; $display("FAIL adj_ignores_dir: got %h want 0012", digits());
    end
    adj = 1'b0; dir = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; adj_tick = 1'b0; adj = 1'b0; sel = 1'b0; pse = 1'b0; dir = 1'b0;
    #1;
    tests++;
    if (digits() !== 16'h0000 || paused !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      fails++; $display("FAIL power_on_reset: got %h p=%b d=%b w=%b want all 0",
                        digits(), paused, done, wrap);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    test_reset();
    test_count_up();
    test_wrap();
    test_count_down();
    test_pause();
    test_adjust();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
